mic1_sequencer: RTL and testbench
=================================

# mic1_sequencer

Microsequencer for the MIC-1 core: owns the single-port-per-direction control store, loads microcode into it from a host port while halted, and during execution fetches microinstructions, presents the MIR to the datapath, and computes the next MPC from NEXT_ADDRESS, JAMN/JAMZ and JMPC. It sits between the control store and the datapath and is the only block that drives the control store's write and read ports.

## Interface
- `ADDR_W`, 9: MPC / control-store address width.
- `WORD_W`, 36: microinstruction width. Fields: NEXT_ADDRESS[35:27], JMPC[26], JAMN[25], JAMZ[24], remaining bits [23:0] are passed through opaque.

Ports:
- `clk` in 1: single clock, all state on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `ld_valid` in 1, `ld_ready` out 1, `ld_addr` in 9, `ld_data` in 36: host microcode load handshake.
- `start` in 1, `start_addr` in 9: begin execution at `start_addr`.
- `halt_req` in 1: stop at the next microinstruction boundary.
- `mem_busy` in 1: datapath memory stall; holds the current microinstruction.
- `dp_n`, `dp_z` in 1: ALU flags, valid during EXEC.
- `mbr` in 8: MBR value for JMPC, valid during EXEC.
- `cs_wen`, `cs_ren` out 1; `cs_waddr`, `cs_raddr` out 9; `cs_wdata` out 36; `cs_rdata` in 36: control store port, with 1-cycle registered read latency.
- `mir` out 36: equals `cs_rdata` during EXEC, 0 otherwise.
- `mir_valid` out 1: high during each EXEC cycle.
- `mpc` out 9: address of the current or next microinstruction.
- `halted` out 1: high in IDLE.
- `ucount` out 32: count of retired microinstructions.
- `bkpt_addr` in 9: breakpoint address; used only with the macro.

## Operation
- States:
  - IDLE: halted, loads accepted.
  - FETCH: `cs_ren`=1, `cs_raddr`=`mpc`.
  - EXEC: MIR valid; datapath runs.
- IDLE:
  - `ld_ready`=1.
  - On `ld_valid`: `cs_wen`=1, `cs_waddr`=`ld_addr`, `cs_wdata`=`ld_data` in the same cycle, combinationally.
  - `start` and `ld_valid` together: the load wins; `start` is ignored that cycle.
  - `start` alone: `mpc`<=`start_addr`, go to FETCH.
- Outside IDLE: `ld_ready`=0, `cs_wen`=0, and `ld_valid` is ignored.
- FETCH always goes to EXEC next cycle.
- EXEC with `mem_busy`=1: stay in EXEC; `mir` is held because the control store read is not re-issued and `rdata` holds. `ucount` does not advance.
- EXEC with `mem_busy`=0 (retire):
  - `ucount`++, wrapping at 2^32.
  - `mpc` <= { NEXT_ADDRESS[8] | (JAMN&`dp_n`) | (JAMZ&`dp_z`), NEXT_ADDRESS[7:0] | (JMPC ? `mbr` : 8'h00) }.
  - Go to IDLE if `halt_req` is high that cycle, else FETCH.
- `halt_req` sampled in FETCH is remembered (sticky) and applied at the following retire.
- `halt_req` in IDLE has no effect.
- Next-address arithmetic is pure OR, with no carry. MPC wraps naturally within 9 bits.
- Reset, asynchronous at any time including mid-EXEC: state=IDLE, `mpc`=0, `ucount`=0, sticky halt cleared.
- Output values in reset: `cs_wen`=`cs_ren`=0, `mir`=0, `mir_valid`=0, `halted`=1, `ld_ready`=1 once `rst` deasserts.
- Control store contents are not affected by reset.

## Timing
- Throughput: 2 cycles per microinstruction, plus 1 cycle per `mem_busy` cycle.
- `start` at cycle t: FETCH at t+1, EXEC (`mir_valid`=1) at t+2.
- Next FETCH follows the retire cycle with the new `mpc`.
- Load: 1 word per cycle in IDLE, zero latency to `cs_wen`.
- A word written at cycle t is readable by a FETCH at t+1 or later.
- `halted` rises the cycle after the retire that consumes a halt.

## Configuration
- `MIC1_SEQ_BKPT_EN` defined: on retire, if the computed next `mpc` equals `bkpt_addr`, go to IDLE instead of FETCH.
  - `mpc` holds the breakpoint address, so `start` with `start_addr`=`mpc` resumes.
  - A breakpoint on `start_addr` itself does not trigger on `start`.
- Undefined: `bkpt_addr` is ignored and no breakpoint logic is synthesized.

## Test plan
- Reset/load:
  - After `rst`: `halted`=1, `mpc`=0, `ucount`=0.
  - Load 16 words at addr 0..15 -> `cs_wen` pulses 16 cycles with matching addr/data and `ld_ready`=1 throughout.
- Sequencing: words chain 0->1->2 via NEXT_ADDRESS, `start` with `start_addr`=0 -> `mir_valid` every other cycle; `mpc` goes 0,1,2; `ucount`=3 after 3 retires.
- Jumps:
  - Word NEXT_ADDRESS=0x010 with JAMZ=1, `dp_z`=1 -> next `mpc`=0x110.
  - Same word with `dp_z`=0 -> 0x010.
  - JMPC=1, NEXT_ADDRESS=0x100, `mbr`=0x5A -> 0x15A.
- Stall: `mem_busy` high for 3 EXEC cycles -> `mir` stable, `ucount` unchanged, retire on the 4th cycle.
- Halt/load exclusion:
  - `halt_req` pulsed in FETCH -> IDLE after the next retire.
  - `ld_valid` during FETCH/EXEC -> `cs_wen` stays 0.
  - `start` + `ld_valid` together in IDLE -> write occurs, no FETCH.
- Reset mid-EXEC: assert `rst` asynchronously -> `mir_valid`=0, `mpc`=0 immediately; previously loaded microcode is still readable after restart. With `MIC1_SEQ_BKPT_EN`, `bkpt_addr`=2 -> halts with `mpc`=2, `ucount`=2.

Source files
------------

// File: rtl/mic1_sequencer.sv
// MIC-1 microsequencer: control-store loader, microinstruction fetch/execute and next-MPC logic.
// Define MIC1_SEQ_BKPT_EN to build the breakpoint-on-next-MPC feature (bkpt_addr).

module mic1_sequencer #(
    parameter int ADDR_W = 9,
    parameter int WORD_W = 36
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [WORD_W-1:0] ld_data,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              halt_req,
    input  logic              mem_busy,
    input  logic              dp_n,
    input  logic              dp_z,
    input  logic [ADDR_W-2:0] mbr,
    output logic              cs_wen,
    output logic              cs_ren,
    output logic [ADDR_W-1:0] cs_waddr,
    output logic [ADDR_W-1:0] cs_raddr,
    output logic [WORD_W-1:0] cs_wdata,
    input  logic [WORD_W-1:0] cs_rdata,
    output logic [WORD_W-1:0] mir,
    output logic              mir_valid,
    output logic [ADDR_W-1:0] mpc,
    output logic              halted,
    output logic [31:0]       ucount,
    input  logic [ADDR_W-1:0] bkpt_addr
);

    localparam int NA_LSB   = WORD_W - ADDR_W;
    localparam int JMPC_BIT = NA_LSB - 1;
    localparam int JAMN_BIT = NA_LSB - 2;
    localparam int JAMZ_BIT = NA_LSB - 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mpc_q, mpc_d;
    logic [31:0]       ucount_q, ucount_d;
    logic              halt_sticky_q, halt_sticky_d;

    logic [ADDR_W-1:0] next_addr;
    logic              jmpc, jamn, jamz;
    logic [ADDR_W-1:0] next_mpc;
    logic              bkpt_hit;

    // The MIR fields come straight from the control store read data, which holds during stalls.
    assign next_addr = cs_rdata[WORD_W-1:NA_LSB];
    assign jmpc      = cs_rdata[JMPC_BIT];
    assign jamn      = cs_rdata[JAMN_BIT];
    assign jamz      = cs_rdata[JAMZ_BIT];

    assign next_mpc = {next_addr[ADDR_W-1] | (jamn & dp_n) | (jamz & dp_z),
                       next_addr[ADDR_W-2:0] | (jmpc ? mbr : '0)};

`ifdef MIC1_SEQ_BKPT_EN
    assign bkpt_hit = (next_mpc == bkpt_addr);
`else
    logic bkpt_unused;
    assign bkpt_unused = ^bkpt_addr;
    assign bkpt_hit    = 1'b0;
`endif

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            mpc_q         <= '0;
            ucount_q      <= '0;
            halt_sticky_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mpc_q         <= mpc_d;
            ucount_q      <= ucount_d;
            halt_sticky_q <= halt_sticky_d;
        end
    end

    always_comb begin
        // NOTE: each _d defaults to its hold value first, so no branch can infer a latch.
        state_d       = state_q;
        mpc_d         = mpc_q;
        ucount_d      = ucount_q;
        halt_sticky_d = halt_sticky_q;
        case (state_q)
            S_IDLE: begin
                if (!ld_valid && start) begin
                    mpc_d   = start_addr;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_EXEC;
                if (halt_req) halt_sticky_d = 1'b1;
            end
            S_EXEC: begin
                if (!mem_busy) begin
                    ucount_d      = ucount_q + 32'd1;
                    mpc_d         = next_mpc;
                    halt_sticky_d = 1'b0;
                    state_d       = (halt_req || halt_sticky_q || bkpt_hit) ? S_IDLE : S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ld_ready  = 1'b0;
        cs_wen    = 1'b0;
        cs_ren    = 1'b0;
        mir       = '0;
        mir_valid = 1'b0;
        halted    = 1'b0;
        case (state_q)
            S_IDLE: begin
                halted   = 1'b1;
                ld_ready = !rst;
                cs_wen   = ld_valid && !rst;
            end
            S_FETCH: cs_ren = 1'b1;
            S_EXEC: begin
                mir_valid = 1'b1;
                mir       = cs_rdata;
            end
            default: ;
        endcase
    end

    assign cs_waddr = ld_addr;
    assign cs_wdata = ld_data;
    assign cs_raddr = mpc_q;
    assign mpc      = mpc_q;
    assign ucount   = ucount_q;

endmodule

// File: tb/tb_mic1_sequencer.sv
// Directed bench for mic1_sequencer: behavioural control store, scoreboard of expected retires.
// Covers load, sequencing, jumps, stall, halt, load exclusion, async reset and (with MIC1_SEQ_BKPT_EN) breakpoints.

module tb_mic1_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid, ld_ready;
    logic [8:0]  ld_addr;
    logic [35:0] ld_data;
    logic        start;
    logic [8:0]  start_addr;
    logic        halt_req, mem_busy, dp_n, dp_z;
    logic [7:0]  mbr;
    logic        cs_wen, cs_ren;
    logic [8:0]  cs_waddr, cs_raddr;
    logic [35:0] cs_wdata, cs_rdata;
    logic [35:0] mir;
    logic        mir_valid;
    logic [8:0]  mpc;
    logic        halted;
    logic [31:0] ucount;
    logic [8:0]  bkpt_addr;

    always #5 clk = ~clk;

    mic1_sequencer dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .start_addr(start_addr), .halt_req(halt_req), .mem_busy(mem_busy),
        .dp_n(dp_n), .dp_z(dp_z), .mbr(mbr),
        .cs_wen(cs_wen), .cs_ren(cs_ren), .cs_waddr(cs_waddr), .cs_raddr(cs_raddr),
        .cs_wdata(cs_wdata), .cs_rdata(cs_rdata),
        .mir(mir), .mir_valid(mir_valid), .mpc(mpc), .halted(halted), .ucount(ucount),
        .bkpt_addr(bkpt_addr)
    );

    // Control store: synchronous write, registered read that holds when not enabled.
    logic [35:0] cs_mem [0:511];
    always @(posedge clk) begin
        if (cs_wen) cs_mem[cs_waddr] <= cs_wdata;
        if (cs_ren) cs_rdata <= cs_mem[cs_raddr];
    end

    typedef struct {
        logic [35:0] mir;
        logic [8:0]  mpc_now;
        logic [8:0]  mpc_next;
        logic [31:0] ucount;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_ucount = 0;
    logic [35:0] words [0:15];

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [35:0] mk(input logic [8:0] na, input logic j, input logic n,
                                       input logic z, input logic [23:0] low);
        return {na, j, n, z, low};
    endfunction

    task automatic push(input logic [35:0] w, input logic [8:0] now, input logic [8:0] nxt);
        exp_t e;
        exp_ucount = exp_ucount + 32'd1;
        e.mir      = w;
        e.mpc_now  = now;
        e.mpc_next = nxt;
        e.ucount   = exp_ucount;
        exp_q.push_back(e);
    endtask

    // Waits (bounded) for EXEC, checks the popped entry, then checks state after the retire edge.
    task automatic consume(input string tag);
        exp_t e;
        int   budget = 0;
        while (mir_valid !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check({tag, "/exec_seen"}, mir_valid, 1);
        check({tag, "/sb_nonempty"}, exp_q.size() != 0, 1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check({tag, "/mir"}, mir, e.mir);
        check({tag, "/mpc_exec"}, mpc, e.mpc_now);
        @(negedge clk);
        check({tag, "/mpc_next"}, mpc, e.mpc_next);
        check({tag, "/ucount"}, ucount, e.ucount);
    endtask

    // Called at a negedge in IDLE; executes one word with halt_req held so it returns to IDLE.
    task automatic run_single(input string tag, input logic [8:0] addr, input logic [35:0] w,
                              input logic [8:0] nxt);
        push(w, addr, nxt);
        start      = 1'b1;
        start_addr = addr;
        halt_req   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "/fetch"}, {cs_ren, cs_raddr, mir_valid}, {1'b1, addr, 1'b0});
        consume(tag);
        halt_req = 1'b0;
        check({tag, "/halted"}, halted, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [35:0] wnew;
        logic [31:0] stall_uc;

        for (int i = 0; i < 16; i++) words[i] = mk(9'(i + 1), 1'b0, 1'b0, 1'b0, 24'h5A0000 | 24'(i));
        words[3] = mk(9'h010, 1'b0, 1'b0, 1'b1, 24'h000333);
        words[4] = mk(9'h100, 1'b1, 1'b0, 1'b0, 24'h000444);
        words[5] = mk(9'h006, 1'b0, 1'b0, 1'b0, 24'h000555);
        words[7] = mk(9'h0F3, 1'b0, 1'b1, 1'b0, 24'h000777);
        words[8] = mk(9'h1FF, 1'b1, 1'b0, 1'b0, 24'h000888);
        wnew     = mk(9'h0AB, 1'b0, 1'b0, 1'b0, 24'hC0FFEE);

        rst = 1'b1; ld_valid = 1'b1; ld_addr = '0; ld_data = 36'hFFFFFFFFF;
        start = 1'b0; start_addr = '0; halt_req = 1'b0; mem_busy = 1'b0;
        dp_n = 1'b0; dp_z = 1'b0; mbr = '0; bkpt_addr = 9'h1EE;

        // Reset state, with a load request present that must be ignored.
        @(negedge clk);
        check("rst/halted", halted, 1);
        check("rst/mpc", mpc, 0);
        check("rst/ucount", ucount, 0);
        check("rst/outputs", {cs_wen, cs_ren, mir_valid, mir}, 0);
        @(negedge clk);
        rst = 1'b0;
        ld_valid = 1'b0;
        #1 check("rst/ld_ready_after", ld_ready, 1);

        // Load 16 words at one per cycle.
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            ld_valid = 1'b1;
            ld_addr  = 9'(i);
            ld_data  = words[i];
            #1 check("load", {cs_wen, ld_ready, cs_waddr, cs_wdata}, {1'b1, 1'b1, 9'(i), words[i]});
            @(negedge clk);
        end
        ld_valid = 1'b0;
        #1 check("load/idle_after", {cs_wen, halted}, {1'b0, 1'b1});

        // Sequencing 0 -> 1 -> 2, halt pulsed in the third FETCH, load attempts while running.
        push(words[0], 9'd0, 9'd1);
        push(words[1], 9'd1, 9'd2);
        push(words[2], 9'd2, 9'd3);
        start = 1'b1; start_addr = 9'd0;
        @(negedge clk);
        start = 1'b0;
        check("chain/fetch0", {cs_ren, cs_raddr, mir_valid, mir}, {1'b1, 9'd0, 1'b0, 36'd0});
        consume("chain0");
        check("chain/fetch1_gap", {mir_valid, cs_ren}, {1'b0, 1'b1});
        consume("chain1");
        halt_req = 1'b1;
        ld_valid = 1'b1; ld_addr = 9'd5; ld_data = 36'hBADBADBAD;
        #1 check("ld_in_fetch", {cs_wen, ld_ready}, {1'b0, 1'b0});
        @(negedge clk);
        halt_req = 1'b0;
        #1 check("ld_in_exec", {cs_wen, ld_ready}, {1'b0, 1'b0});
        consume("chain2");
        ld_valid = 1'b0;
        check("chain/halted", halted, 1);

        // Jumps: JAMZ taken / not taken, JMPC, JAMN, and OR with no carry.
        dp_z = 1'b1; dp_n = 1'b0;
        run_single("jamz1", 9'd3, words[3], 9'h110);
        dp_z = 1'b0; dp_n = 1'b1;
        run_single("jamz0", 9'd3, words[3], 9'h010);
        dp_z = 1'b1; mbr = 8'h5A;
        run_single("jmpc", 9'd4, words[4], 9'h15A);
        dp_z = 1'b0;
        run_single("jamn", 9'd7, words[7], 9'h1F3);
        mbr = 8'h01;
        run_single("nocarry", 9'd8, words[8], 9'h1FF);

        // Stall: three busy EXEC cycles, retire on the fourth.
        stall_uc = exp_ucount;
        push(words[5], 9'd5, 9'd6);
        mem_busy = 1'b1; start = 1'b1; start_addr = 9'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("stall/mir", {mir_valid, mir}, {1'b1, words[5]});
            check("stall/hold", {cs_ren, ucount}, {1'b0, stall_uc});
            @(negedge clk);
        end
        mem_busy = 1'b0;
        halt_req = 1'b1;
        consume("stall");
        halt_req = 1'b0;
        check("stall/halted", halted, 1);

        // Start together with a load: the write happens and no FETCH follows.
        start = 1'b1; start_addr = 9'd9;
        ld_valid = 1'b1; ld_addr = 9'd9; ld_data = wnew;
        #1 check("startld/write", {cs_wen, cs_waddr, cs_wdata}, {1'b1, 9'd9, wnew});
        @(negedge clk);
        start = 1'b0; ld_valid = 1'b0;
        check("startld/no_fetch", {halted, cs_ren, mir_valid}, {1'b1, 1'b0, 1'b0});
        run_single("newword", 9'd9, wnew, 9'h0AB);

        // Asynchronous reset in the middle of EXEC of the word at address 1.
        start = 1'b1; start_addr = 9'd0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("midexec/before", {mir_valid, mpc}, {1'b1, 9'd1});
        #2 rst = 1'b1;
        #1 check("midexec/after_rst", {mir_valid, mpc, halted, cs_ren, ucount},
                 {1'b0, 9'd0, 1'b1, 1'b0, 32'd0});
        @(negedge clk);
        rst = 1'b0;
        exp_ucount = 0;

`ifdef MIC1_SEQ_BKPT_EN
        bkpt_addr = 9'd2;
        push(words[0], 9'd0, 9'd1);
        push(words[1], 9'd1, 9'd2);
        start = 1'b1; start_addr = 9'd0;
        @(negedge clk);
        start = 1'b0;
        consume("bkpt0");
        consume("bkpt1");
        check("bkpt/halted", halted, 1);
        run_single("bkpt/resume", 9'd2, words[2], 9'd3);
        bkpt_addr = 9'h1EE;
`else
        run_single("restart", 9'd0, words[0], 9'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
